// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state/grant encodings and default widths shared by the I/D memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF  = 32'd6;
  localparam int unsigned DATA_W_DEF  = 32'd32;
  localparam int unsigned TIMEOUT_DEF = 32'd255;
  localparam int unsigned WDOG_W      = 32'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // The side that was not granted last time wins a tie.
  function automatic grant_e other_side(input grant_e g);
    grant_e r;
    case (g)
      GNT_I:   r = GNT_D;
      GNT_D:   r = GNT_I;
      default: r = GNT_I;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// mem_arbiter_rr_pick: combinational two-way round-robin picker for the I and D requesters.
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_e last_grant,
  output grant_e grant,
  output logic   any
);

  // Single requester wins outright; a tie goes to the side not granted last.
  always_comb begin
    any   = req_i | req_d;
    grant = GNT_I;
    if (req_i && req_d) begin
      grant = other_side(last_grant);
    end else if (req_d) begin
      grant = GNT_D;
    end else begin
      grant = GNT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block memory between the I-cache (read-only) and D-cache (read/write),
// with round-robin grant, registered memory-side controls and a watchdog abort.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic              arb_error
);

  localparam logic [WDOG_W-1:0] TIMEOUT_C = WDOG_W'(TIMEOUT);

  arb_state_e        state_q;
  grant_e            grant_q;
  grant_e            last_grant_q;
  logic              seen_busy_q;
  logic [WDOG_W-1:0] wdog_q;
  logic [WDOG_W-1:0] wdog_d;
  logic              arb_error_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_writedata_q;
  logic [DATA_W-1:0] i_readdata_q;
  logic [DATA_W-1:0] d_readdata_q;

  grant_e            pick_grant;
  logic              pick_any;
  logic              d_req;
  logic              i_done;
  logic              d_done;

  assign d_req  = d_read | d_write;
  assign wdog_d = wdog_q + 8'd1;

  mem_arbiter_rr_pick u_pick (
    .req_i      (i_read),
    .req_d      (d_req),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  // Arbitration FSM with the watchdog, memory-side registers and per-side readdata registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= IDLE;
      grant_q         <= GNT_I;
      last_grant_q    <= GNT_D;
      seen_busy_q     <= 1'b0;
      wdog_q          <= {WDOG_W{1'b0}};
      arb_error_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= {ADDR_W{1'b0}};
      mem_writedata_q <= {DATA_W{1'b0}};
      i_readdata_q    <= {DATA_W{1'b0}};
      d_readdata_q    <= {DATA_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q     <= pick_grant;
            seen_busy_q <= 1'b0;
            wdog_q      <= {WDOG_W{1'b0}};
            state_q     <= BUSY;
            if (pick_grant == GNT_D) begin
              // An illegal read+write request is carried out as a write.
              mem_address_q   <= d_address;
              mem_writedata_q <= d_writedata;
              mem_write_q     <= d_write;
              mem_read_q      <= d_read & ~d_write;
            end else begin
              mem_address_q   <= i_address;
              mem_writedata_q <= {DATA_W{1'b0}};
              mem_write_q     <= 1'b0;
              mem_read_q      <= 1'b1;
            end
          end
        end
        BUSY: begin
          // A low busywait only means completion once the memory has been seen busy.
          if (!mem_busywait && seen_busy_q) begin
            if (mem_read_q) begin
              if (grant_q == GNT_D) begin
                d_readdata_q <= mem_readdata;
              end else begin
                i_readdata_q <= mem_readdata;
              end
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= DONE;
          end else if (wdog_q == TIMEOUT_C) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            arb_error_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            wdog_q <= wdog_d;
            if (mem_busywait) begin
              seen_busy_q <= 1'b1;
            end
          end
        end
        DONE: begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // The winner is released only during its single DONE cycle.
  assign i_done = (state_q == DONE) && (grant_q == GNT_I);
  assign d_done = (state_q == DONE) && (grant_q == GNT_D);

  assign i_busywait    = i_read & ~i_done;
  assign d_busywait    = d_req & ~d_done;
  assign i_readdata    = i_readdata_q;
  assign d_readdata    = d_readdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign arb_error     = arb_error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven, hand-sequenced and randomized checks of mem_arbiter against
// a behavioural memory and a scoreboard of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TO = 255;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;
  logic          mem_busywait = 1'b0;
  logic          arb_error;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .arb_error(arb_error)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural block memory: optional quiet period, then busy for lat cycles, then done.
  logic [DW-1:0] mem_arr [64];
  int cfg_lat = 5, cfg_pre = 0;
  bit cfg_hang = 1'b0, cfg_rand = 1'b0;
  int m_phase = 0, m_cnt = 0;

  always @(negedge CLK) begin : mem_model
    int lat_v, pre_v;
    if (!(mem_read || mem_write)) begin
      m_phase = 0;
      mem_busywait = 1'b0;
    end else begin
      lat_v = cfg_rand ? int'($urandom_range(4, 1)) : cfg_lat;
      pre_v = cfg_rand ? int'($urandom_range(2, 0)) : cfg_pre;
      case (m_phase)
        0: begin
          if (pre_v > 0) begin
            m_cnt = pre_v; m_phase = 1;
          end else begin
            mem_busywait = 1'b1; m_cnt = lat_v; m_phase = 2;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            mem_busywait = 1'b1; m_cnt = lat_v; m_phase = 2;
          end
        end
        2: begin
          if (!cfg_hang) begin
            m_cnt--;
            if (m_cnt == 0) begin
              if (mem_write) begin
                mem_arr[mem_address] = mem_writedata;
                mem_readdata = $urandom;
              end else begin
                mem_readdata = mem_arr[mem_address];
              end
              mem_busywait = 1'b0;
              m_phase = 3;
            end
          end
        end
        default: ;
      endcase
    end
  end

  typedef struct {
    bit          side;      // 0 = I, 1 = D
    bit          rd;
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    int          lat;
    int          pre;
    bit          exp_rd;
    bit          exp_wr;
    logic [31:0] exp_rdata;  // requester's readdata after the transaction
    int          exp_hi;     // cycles mem_read/mem_write stays high
  } vec_t;

  task automatic run_vec(input string nm, input vec_t v);
    int  hi = 0, n = 0, bad = 0, other_bad = 0;
    bit  done = 1'b0;
    cfg_lat = v.lat; cfg_pre = v.pre;
    if (v.side) begin
      d_read = v.rd; d_write = v.wr; d_address = v.addr; d_writedata = v.wdata;
    end else begin
      i_read = 1'b1; i_address = v.addr;
    end
    while (!done && n < 600) begin
      @(negedge CLK); n++;
      if (v.side ? d_busywait : i_busywait) begin
        if (mem_read || mem_write) begin
          hi++;
          if (mem_read !== v.exp_rd || mem_write !== v.exp_wr || mem_address !== v.addr) bad++;
          if (v.exp_wr && mem_writedata !== v.wdata) bad++;
        end
        if ((v.side ? i_busywait : d_busywait) !== 1'b0) other_bad++;
      end else begin
        done = 1'b1;
      end
    end
    chk({nm, " released"}, done, 1'b1);
    chk({nm, " op cycles"}, hi, v.exp_hi);
    chk({nm, " mem ctrl"}, bad, 0);
    chk({nm, " idle side"}, other_bad, 0);
    chk({nm, " readdata"}, v.side ? d_readdata : i_readdata, v.exp_rdata);
    @(negedge CLK);
    chk({nm, " busy after done"}, v.side ? d_busywait : i_busywait, 1'b1);
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic run_pair(input string nm, input logic [5:0] ia, input logic [31:0] iexp,
                          input logic [5:0] da, input bit dwr, input logic [31:0] dwd,
                          input logic [31:0] dexp, input bit exp_first);
    int         order [2];
    logic [5:0] saddr [2];
    int         nd = 0, ns = 0, n = 0;
    bit         prev = 1'b0, id = 1'b0, dd = 1'b0;
    order[0] = -1; order[1] = -1; saddr[0] = '0; saddr[1] = '0;
    i_read = 1'b1; i_address = ia;
    d_read = !dwr; d_write = dwr; d_address = da; d_writedata = dwd;
    while ((!id || !dd) && n < 300) begin
      @(negedge CLK); n++;
      if ((mem_read || mem_write) && !prev && ns < 2) begin
        saddr[ns] = mem_address; ns++;
      end
      prev = mem_read || mem_write;
      if (!id && !i_busywait) begin
        chk({nm, " I readdata"}, i_readdata, iexp);
        id = 1'b1; i_read = 1'b0; order[nd] = 0; nd++;
      end
      if (!dd && !d_busywait) begin
        if (!dwr) chk({nm, " D readdata"}, d_readdata, dexp);
        dd = 1'b1; d_read = 1'b0; d_write = 1'b0; order[nd] = 1; nd++;
      end
    end
    chk({nm, " both served"}, {id, dd}, 2'b11);
    chk({nm, " first winner"}, order[0], exp_first ? 1 : 0);
    chk({nm, " first addr"}, saddr[0], exp_first ? da : ia);
    chk({nm, " second addr"}, saddr[1], exp_first ? ia : da);
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  vec_t vecs [8];
  vec_t wv;
  logic [31:0] ref_mem [64];

  initial begin
    #2_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int a = 0; a < 64; a++) mem_arr[a] = 32'hA5A50000 | a;
    mem_arr[1] = 32'h11111111; mem_arr[2] = 32'h22222222;
    mem_arr[6'h21] = 32'h21212121; mem_arr[6'h22] = 32'h22220000;

    //            side  rd    wr    addr   wdata         lat pre erd   ewr   exp_rdata     hi
    vecs[0] = '{1'b1, 1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 3, 0, 1'b0, 1'b1, 32'h22222222, 4};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 6'h05, 32'h00000000, 5, 0, 1'b1, 1'b0, 32'hDEADBEEF, 6};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 6'h3F, 32'h12345678, 5, 0, 1'b0, 1'b1, 32'h22222222, 6};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 6'h3F, 32'h00000000, 2, 0, 1'b1, 1'b0, 32'h12345678, 3};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 6'h3F, 32'h00000000, 4, 3, 1'b1, 1'b0, 32'h12345678, 8};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 6'h00, 32'h00000000, 3, 1, 1'b1, 1'b0, 32'hA5A50000, 5};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 6'h10, 32'hCAFEF00D, 1, 0, 1'b0, 1'b1, 32'hA5A50000, 2};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 6'h10, 32'h00000000, 1, 2, 1'b1, 1'b0, 32'hCAFEF00D, 4};

    // Reset state, sampled while RESET is held low.
    #3;
    chk("rst mem_read", mem_read, 1'b0);
    chk("rst mem_write", mem_write, 1'b0);
    chk("rst mem_address", mem_address, 6'h00);
    chk("rst mem_writedata", mem_writedata, 32'h0);
    chk("rst i_readdata", i_readdata, 32'h0);
    chk("rst d_readdata", d_readdata, 32'h0);
    chk("rst arb_error", arb_error, 1'b0);
    chk("rst busywaits", {i_busywait, d_busywait}, 2'b00);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    cfg_lat = 3; cfg_pre = 0;
    run_pair("pair1", 6'h01, 32'h11111111, 6'h02, 1'b0, 32'h0, 32'h22222222, 1'b0);
    for (int k = 0; k < 8; k++) run_vec($sformatf("vec%0d", k), vecs[k]);
    cfg_lat = 3; cfg_pre = 0;
    run_pair("pair2", 6'h21, 32'h21212121, 6'h22, 1'b0, 32'h0, 32'h22220000, 1'b1);
    chk("arb_error before hang", arb_error, 1'b0);

    // Memory never completes: watchdog abort after TIMEOUT+1 cycles with stale readdata.
    cfg_hang = 1'b1;
    wv = '{1'b0, 1'b1, 1'b0, 6'h07, 32'h0, 5, 0, 1'b1, 1'b0, 32'h21212121, TO + 1};
    run_vec("wdog", wv);
    cfg_hang = 1'b0;
    chk("arb_error after abort", arb_error, 1'b1);
    wv = '{1'b0, 1'b1, 1'b0, 6'h07, 32'h0, 2, 0, 1'b1, 1'b0, 32'hA5A50007, 3};
    run_vec("post-abort", wv);
    chk("arb_error sticky", arb_error, 1'b1);

    // Asynchronous reset while a D write is in flight; next tie must go to I.
    cfg_lat = 10;
    d_write = 1'b1; d_address = 6'h2A; d_writedata = 32'h0BADCAFE;
    repeat (3) @(negedge CLK);
    chk("pre-reset mem_write", mem_write, 1'b1);
    #2 RESET = 1'b0;
    #1;
    chk("async rst mem_write", mem_write, 1'b0);
    chk("async rst mem_read", mem_read, 1'b0);
    chk("async rst mem_address", mem_address, 6'h00);
    chk("async rst arb_error", arb_error, 1'b0);
    chk("async rst d_busywait", d_busywait, 1'b1);
    @(negedge CLK);
    RESET = 1'b1;
    cfg_lat = 3;
    run_pair("post-reset", 6'h21, 32'h21212121, 6'h2A, 1'b1, 32'h0BADCAFE, 32'h0, 1'b0);

    // Randomized traffic against the arbitration rules and a scoreboard memory.
    @(negedge CLK) RESET = 1'b0;
    @(negedge CLK) RESET = 1'b1;
    for (int a = 0; a < 64; a++) begin
      mem_arr[a] = (a * 32'h01010101) ^ 32'h5A5A5A5A;
      ref_mem[a] = (a * 32'h01010101) ^ 32'h5A5A5A5A;
    end
    cfg_rand = 1'b1;
    begin : rand_phase
      bit          act [2];
      logic [5:0]  ad [2];
      int          rq [2];
      int          gap [2];
      bit          d_wr_r = 1'b0, prev_op = 1'b0, op, p0, p1;
      logic [31:0] wd = 32'h0;
      int          cur_w = -1, last_m = 1, ncomp = 0, ew;
      for (int s = 0; s < 2; s++) begin act[s] = 1'b0; ad[s] = '0; rq[s] = 0; gap[s] = 1; end
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge CLK);
        op = mem_read || mem_write;
        if (op && !prev_op) begin
          p0 = act[0] && (rq[0] < cyc);
          p1 = act[1] && (rq[1] < cyc);
          if (p0 && p1) ew = (last_m == 0) ? 1 : 0;
          else ew = p1 ? 1 : 0;
          chk("rand start addr", mem_address, ad[ew]);
          chk("rand start op", {mem_read, mem_write}, (ew == 1 && d_wr_r) ? 2'b01 : 2'b10);
          cur_w = ew;
        end
        prev_op = op;
        for (int s = 0; s < 2; s++) begin
          if (act[s] && !((s == 0) ? i_busywait : d_busywait)) begin
            chk("rand grant order", s, cur_w);
            if (s == 1 && d_wr_r) ref_mem[ad[1]] = wd;
            else chk("rand readdata", (s == 0) ? i_readdata : d_readdata, ref_mem[ad[s]]);
            last_m = s; act[s] = 1'b0; ncomp++;
            gap[s] = int'($urandom_range(4, 1));
            if (s == 0) i_read = 1'b0;
            else begin d_read = 1'b0; d_write = 1'b0; end
          end
        end
        for (int s = 0; s < 2; s++) begin
          if (!act[s]) begin
            if (gap[s] > 0) gap[s]--;
            else if ($urandom_range(2, 0) == 0) begin
              act[s] = 1'b1; rq[s] = cyc; ad[s] = 6'($urandom_range(63, 0));
              if (s == 0) begin
                i_read = 1'b1; i_address = ad[0];
              end else begin
                d_wr_r = 1'($urandom_range(1, 0)); wd = $urandom;
                d_read = !d_wr_r; d_write = d_wr_r; d_address = ad[1]; d_writedata = wd;
              end
            end
          end
        end
      end
      chk("rand progress", (ncomp > 50) ? 1 : 0, 1);
      chk("rand arb_error", arb_error, 1'b0);
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
